// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and constants for the CPU data-memory path
package cpu_mem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } mem_resp_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response handshake bundle between CPU and data memory
interface data_mem_responder_if
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with byte-enable write port and registered read port
module dmem_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are intentionally left uninitialised; rdata only moves on re.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store responder with programmable wait states
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus
);
    localparam int         AW   = $clog2(DEPTH);
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              lat_we;
    logic              lat_err;
    logic [AW-1:0]     lat_idx;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic              load_ok_q;
    logic [DATA_W-1:0] arr_rdata;
    logic              accept;
    logic              access;
    logic              arr_we;
    logic              arr_re;

    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (32'(a[ADDR_W-1:2]) >= 32'(DEPTH));
    endfunction

    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    // The array is touched only in the first RESP cycle, before resp_valid rises.
    assign access = (state == RESP) && !resp_valid_q && !rst;
    assign arr_we = access && lat_we && !lat_err;
    assign arr_re = access && !lat_we && !lat_err;

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= bus.req_we;
            lat_err   <= addr_err(bus.req_addr);
            lat_idx   <= bus.req_addr[AW+1:2];
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            load_ok_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wait_cnt <= LAT4;
                        state    <= (LAT4 == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        wait_cnt <= '0;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= lat_err;
                        load_ok_q    <= !lat_we && !lat_err;
                    end else if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        load_ok_q    <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = load_ok_q ? arr_rdata : '0;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (lat_idx),
        .be    (lat_be),
        .wdata (lat_wdata),
        .re    (arr_re),
        .raddr (lat_idx),
        .rdata (arr_rdata)
    );
endmodule
